mem_resp_model: RTL
===================

MEM_RESP_MODEL -- requirements
Module: mem_resp_model

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning request-to-mem_ready cycle count; legal range 1..15.
REQ-002 SHALL have parameter IDX_W, default 8, meaning line-index width (2^IDX_W lines of 128 bits).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port proc_reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port mem_read  input  1  read-line request, held by initiator until mem_ready.
REQ-006 SHALL have port mem_write  input  1  write-line request, held by initiator until mem_ready.
REQ-007 SHALL have port mem_addr  input  28  line address (word address bits [29:2]).
REQ-008 SHALL have port mem_wdata  input  128  write line; word0 in [31:0], word3 in [127:96].
REQ-009 SHALL have port mem_rdata  output  128  read line, same word order, valid only while mem_ready=1.
REQ-010 SHALL have port mem_ready  output  1  one-cycle completion pulse.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-012 IDLE: on mem_read|mem_write high, SHALL latch command, mem_addr[IDX_W-1:0], mem_wdata; load counter with LATENCY-1; go to RESP if LATENCY=1, else WAIT.
REQ-013 WAIT: SHALL decrement counter each cycle; go to RESP in the cycle after it reaches 1.
REQ-014 RESP: SHALL drive mem_ready=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-015 Latency: request first high in cycle 0 (state IDLE) SHALL give mem_ready high in exactly cycle LATENCY.
REQ-016 Read: mem_rdata in RESP SHALL equal stored line at latched index.
REQ-017 Write: stored line at latched index SHALL update with latched wdata at the RESP-cycle edge; mem_rdata in that cycle SHALL show the pre-write line.
REQ-018 mem_read and mem_write both high at acceptance SHALL be treated as write (REQ-017 applies).
REQ-019 Inputs changing during WAIT/RESP SHALL be ignored; only latched values used.
REQ-020 Request still high in the IDLE cycle after RESP SHALL be accepted as a new transaction (back-to-back allowed).
REQ-021 mem_addr bits above IDX_W-1 SHALL be ignored (aliasing permitted).
REQ-022 mem_rdata SHALL be 128'b0 whenever mem_ready=0.
REQ-023 mem_ready and mem_rdata SHALL be driven from flops (no combinational input-to-output path).

Reset
REQ-024 proc_reset SHALL force state IDLE, counter 0, mem_ready 0, mem_rdata 0 at the next edge, taking precedence over all else.
REQ-025 Reset during WAIT/RESP SHALL abort the transaction; a pending write SHALL NOT commit.
REQ-026 Line storage SHALL NOT be cleared by reset; contents before first write are undefined.

Structure
REQ-027 Shared package SHALL hold state encoding, LINE_W=128, MEM_ADDR_W=28, and LATENCY default.
REQ-028 Storage SHALL be one sub-module mem_line_array: 2^IDX_W x 128, one synchronous write port, one read port.
REQ-029 Top SHALL contain FSM, counter, request latches, output registers only.

Verification
REQ-030 Reset then write addr 0x0000005, wdata 0x44444444_33333333_22222222_11111111, LATENCY=4 -> mem_ready high only in cycle 4; read addr 5 -> mem_rdata equals that line in cycle 4, 0 otherwise.
REQ-031 Back-to-back reads of 0x05 and 0x06, mem_read held -> two single-cycle mem_ready pulses separated by LATENCY+1 cycles, correct data each.
REQ-032 mem_read and mem_write both high, addr 0x07 holding 0xA..A, wdata 0xB..B -> mem_rdata=0xA..A at ready; later read returns 0xB..B.
REQ-033 mem_addr changed 0x05->0x09 during WAIT -> response data is line 0x05.
REQ-034 proc_reset asserted in WAIT of write to 0x08 (prior 0xC..C) -> no mem_ready, state IDLE; later read of 0x08 returns 0xC..C.
REQ-035 LATENCY=1 build, read 0x05 -> mem_ready in cycle 1; addr 0x100 with IDX_W=8 -> returns line 0x00.

Source files
------------

// File: rtl/mem_resp_model_pkg.sv
// Shared definitions for the fixed-latency line memory response model:
// state encoding, interface widths and the default latency.
package mem_resp_model_pkg;

  localparam int unsigned LINE_W      = 128;
  localparam int unsigned MEM_ADDR_W  = 28;
  localparam int unsigned LATENCY_DEF = 4;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_resp_model_line_array.sv
// Line storage: 2^IDX_W lines, one synchronous write port, one asynchronous read port.
// Contents are never reset.
module mem_line_array #(
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [LINE_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] lines [2**IDX_W];

  always_ff @(posedge clk) begin
    if (we) lines[waddr] <= wdata;
  end

  assign rdata = lines[raddr];

endmodule

// File: rtl/mem_resp_model.sv
// Fixed-latency line memory response model: latches a read/write request,
// waits LATENCY cycles, then pulses mem_ready with registered read data.
module mem_resp_model
  import mem_resp_model_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEF,
  parameter int unsigned IDX_W   = 8
) (
  input  logic                  clk,
  input  logic                  proc_reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0]     mem_wdata,
  output logic [LINE_W-1:0]     mem_rdata,
  output logic                  mem_ready
);

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic              cmd_wr;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic [IDX_W-1:0]  rd_idx;
  logic [LINE_W-1:0] rd_line;
  logic              req;
  logic              we;

  assign req = mem_read | mem_write;

  // With LATENCY=1 the response is captured on the acceptance edge, so the
  // read index must come straight from the bus while still in IDLE.
  assign rd_idx = (state == IDLE) ? mem_addr[IDX_W-1:0] : idx_q;

  // A write commits on the RESP edge unless reset aborts it.
  assign we = (state == RESP) && cmd_wr && !proc_reset;

  if (IDX_W < MEM_ADDR_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[MEM_ADDR_W-1:IDX_W];
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == CNT_W'(1)) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      state     <= next_state;
      mem_ready <= (next_state == RESP);
      mem_rdata <= (next_state == RESP) ? rd_line : '0;
      case (state)
        IDLE: if (req) begin
          cmd_wr  <= mem_write;
          idx_q   <= mem_addr[IDX_W-1:0];
          wdata_q <= mem_wdata;
          cnt     <= CNT_W'(LATENCY - 1);
        end
        WAIT:    cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  mem_line_array #(
    .IDX_W  (IDX_W),
    .LINE_W (LINE_W)
  ) u_lines (
    .clk   (clk),
    .we    (we),
    .waddr (idx_q),
    .wdata (wdata_q),
    .raddr (rd_idx),
    .rdata (rd_line)
  );

endmodule
